// File: rtl/fpga_dsp_stream_io_if.sv
// Bundle of the FIR-side AXI4-Stream pair and the HPS-side APB slave port
// for the CPU stream endpoint.
interface fpga_dsp_stream_io_if;
    logic [7:0]  axis4_m_tdata;
    logic        axis4_m_tvalid;
    logic        axis4_m_tready;
    logic        axis4_m_tlast;

    logic [7:0]  axis4_s_tdata;
    logic        axis4_s_tvalid;
    logic        axis4_s_tready;
    logic        axis4_s_tlast;

    logic [3:0]  apb_slave_paddr;
    logic        apb_slave_psel;
    logic        apb_slave_penable;
    logic        apb_slave_pwrite;
    logic [31:0] apb_slave_pwdata;
    logic [31:0] apb_slave_prdata;
    logic        apb_slave_pready;

    // The endpoint itself: APB slave, AXIS master on TX, AXIS slave on RX.
    modport slave (
        output axis4_m_tdata, axis4_m_tvalid, axis4_m_tlast,
        input  axis4_m_tready,
        input  axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
        output axis4_s_tready,
        input  apb_slave_paddr, apb_slave_psel, apb_slave_penable,
        input  apb_slave_pwrite, apb_slave_pwdata,
        output apb_slave_prdata, apb_slave_pready
    );

    // The environment around it: CPU bridge plus filter.
    modport master (
        input  axis4_m_tdata, axis4_m_tvalid, axis4_m_tlast,
        output axis4_m_tready,
        output axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
        input  axis4_s_tready,
        output apb_slave_paddr, apb_slave_psel, apb_slave_penable,
        output apb_slave_pwrite, apb_slave_pwdata,
        input  apb_slave_prdata, apb_slave_pready
    );
endinterface

// File: rtl/fpga_dsp_stream_io.sv
// APB-programmed stream endpoint: TX FIFO + output register toward the FIR
// AXIS slave, RX FIFO capturing the FIR AXIS output for CPU readback.
module fpga_dsp_stream_io #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    fpga_dsp_stream_io_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic        access, wr, rd;
    logic [1:0]  addr;
    logic        ctrl_wr, tx_flush, rx_flush;

    logic        tx_en, tx_ovf, rx_ovf;
    logic [8:0]  tx_mem [DEPTH];
    logic [8:0]  rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [LW-1:0] tx_level, rx_level;
    logic        tx_vld, tx_last;
    logic [7:0]  tx_data;

    logic        tx_full, tx_push_req, tx_push, tx_load;
    logic        rx_full, rx_empty, rx_push, rx_pop;
    logic [8:0]  rx_head;
    logic [15:0] tx_lvl16, rx_lvl16;
    logic        unused;

    assign access  = bus.apb_slave_psel & bus.apb_slave_penable;
    assign wr      = access & bus.apb_slave_pwrite;
    assign rd      = access & ~bus.apb_slave_pwrite;
    assign addr    = bus.apb_slave_paddr[3:2];
    assign ctrl_wr = wr & (addr == 2'd0);
    assign tx_flush = ctrl_wr & bus.apb_slave_pwdata[1];
    assign rx_flush = ctrl_wr & bus.apb_slave_pwdata[2];

    assign tx_full     = (tx_level == LW'(DEPTH));
    assign tx_push_req = wr & (addr == 2'd1);
    assign tx_push     = tx_push_req & ~tx_full;
    // The output register refills whenever it is free or its beat completes.
    assign tx_load     = tx_en & (tx_level != '0) & (~tx_vld | bus.axis4_m_tready);

    assign rx_full  = (rx_level == LW'(DEPTH));
    assign rx_empty = (rx_level == '0);
    assign rx_push  = bus.axis4_s_tvalid & ~rx_full;
    assign rx_pop   = rd & (addr == 2'd2) & ~rx_empty;
    assign rx_head  = rx_mem[rx_rp];

    assign tx_lvl16 = 16'(tx_level);
    assign rx_lvl16 = 16'(rx_level);
    assign unused   = ^{bus.apb_slave_pwdata[31:9], bus.apb_slave_paddr[1:0]};

    assign bus.axis4_m_tdata    = tx_data;
    assign bus.axis4_m_tvalid   = tx_vld;
    assign bus.axis4_m_tlast    = tx_last;
    assign bus.axis4_s_tready   = ~rx_full;
    assign bus.apb_slave_pready = 1'b1;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.apb_slave_pwdata[8:0];
        if (rx_push) rx_mem[rx_wp] <= {bus.axis4_s_tlast, bus.axis4_s_tdata};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_en    <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_level <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_level <= '0;
            tx_vld   <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
        end else begin
            if (ctrl_wr) tx_en <= bus.apb_slave_pwdata[0];

            if (tx_push_req & tx_full)              tx_ovf <= 1'b1;
            else if (ctrl_wr & bus.apb_slave_pwdata[3]) tx_ovf <= 1'b0;
            if (bus.axis4_s_tvalid & rx_full)       rx_ovf <= 1'b1;
            else if (ctrl_wr & bus.apb_slave_pwdata[4]) rx_ovf <= 1'b0;

            if (tx_flush) begin
                tx_wp    <= '0;
                tx_rp    <= '0;
                tx_level <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + 1'b1;
                if (tx_load) tx_rp <= tx_rp + 1'b1;
                if (tx_push & ~tx_load)      tx_level <= tx_level + 1'b1;
                else if (~tx_push & tx_load) tx_level <= tx_level - 1'b1;
            end

            // Flush drops a pending beat; otherwise hold until accepted.
            if (tx_flush) begin
                tx_vld <= 1'b0;
            end else if (tx_load) begin
                tx_vld  <= 1'b1;
                tx_data <= tx_mem[tx_rp][7:0];
                tx_last <= tx_mem[tx_rp][8];
            end else if (bus.axis4_m_tready) begin
                tx_vld <= 1'b0;
            end

            if (rx_flush) begin
                rx_wp    <= '0;
                rx_rp    <= '0;
                rx_level <= '0;
            end else begin
                if (rx_push) rx_wp <= rx_wp + 1'b1;
                if (rx_pop)  rx_rp <= rx_rp + 1'b1;
                if (rx_push & ~rx_pop)      rx_level <= rx_level + 1'b1;
                else if (~rx_push & rx_pop) rx_level <= rx_level - 1'b1;
            end
        end
    end

    always_comb begin
        bus.apb_slave_prdata = 32'hFFFF_FFFF;
        if (rd) begin
            case (addr)
                2'd0: bus.apb_slave_prdata = {18'b0, rx_ovf, tx_ovf, rx_empty, rx_full,
                                              (tx_level == '0) & ~tx_vld, tx_full,
                                              7'b0, tx_en};
                2'd1: bus.apb_slave_prdata = 32'h0;
                2'd2: bus.apb_slave_prdata = rx_empty ? 32'h8000_0000
                                                      : {23'b0, rx_head};
                default: bus.apb_slave_prdata = {8'b0, rx_lvl16[7:0], 8'b0, tx_lvl16[7:0]};
            endcase
        end
    end
endmodule
